// File: rtl/flow_block_mux.sv
// rtl/flow_block_mux.sv - block round-robin merge of per-flow FWFT sources into one tagged stream
//
// Purpose: merges FLUX first-word-fall-through source FIFOs into a single
// {flow_id, data} write stream. Each flow is sent in blocks of blk_len words,
// flows take turns round-robin, and flows whose word budget is exhausted are skipped.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   cfg_we        write blk_len/total for cfg_flow (accepted in IDLE only)
//   cfg_flow      flow being configured
//   cfg_blk_len   words per block (0 behaves as 1)
//   cfg_total     total words for the flow (0 = inactive)
//   cfg_go        start transmission (accepted in IDLE only)
//   src_din       per-flow head words, flow f at [f*DATA_W +: DATA_W]
//   src_empty     per-flow source empty
//   src_read      per-flow pop strobe (one-hot or zero)
//   out_din       {flow_id, data}, zero when nothing is written
//   out_write     out_din valid and consumed this cycle
//   out_full      per-flow downstream full (only the current flow's bit matters)
//   busy          transmission in progress
//   done          one-cycle pulse after the final word has been written
//   cfg_err       one-cycle pulse for config during RUN or go with nothing to send

module flow_block_mux #(
    parameter int FLUX   = 2,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 7,
    parameter int CNT_W  = 16,
    localparam int TAG_W = (FLUX > 1) ? $clog2(FLUX) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [TAG_W-1:0]         cfg_flow,
    input  logic [LEN_W-1:0]         cfg_blk_len,
    input  logic [CNT_W-1:0]         cfg_total,
    input  logic                     cfg_go,
    input  logic [FLUX*DATA_W-1:0]   src_din,
    input  logic [FLUX-1:0]          src_empty,
    output logic [FLUX-1:0]          src_read,
    output logic [TAG_W+DATA_W-1:0]  out_din,
    output logic                     out_write,
    input  logic [FLUX-1:0]          out_full,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [CNT_W-1:0]   remaining [FLUX];
    logic [LEN_W-1:0]   blk_len   [FLUX];
    logic [TAG_W-1:0]   cur;
    logic [LEN_W-1:0]   blk_cnt;
    logic               done_r;
    logic               cfg_err_r;

    logic               cfg_flow_ok;
    logic               xfer;
    logic [DATA_W-1:0]  head;
    logic [CNT_W-1:0]   rem_cur_dec;
    logic               blk_end;
    logic               nxt_found;
    logic [TAG_W-1:0]   nxt_flow;
    logic               start_found;
    logic [TAG_W-1:0]   start_flow;

    assign cfg_flow_ok = (int'(cfg_flow) < FLUX);

    // Transfer happens only when the current flow has data and room downstream.
    always_comb begin
        xfer = 1'b0;
        if (state == S_RUN) begin
            xfer = !src_empty[cur] && !out_full[cur];
        end
    end

    always_comb begin
        head = src_din[int'(cur)*DATA_W +: DATA_W];
    end

    // A block closes on its last word or on the flow's last word.
    always_comb begin
        rem_cur_dec = remaining[cur] - CNT_W'(1);
        blk_end     = ((blk_cnt + LEN_W'(1)) == blk_len[cur]) || (remaining[cur] == CNT_W'(1));
    end

    // Next flow after cur with words left once this transfer is counted.
    // Scanning from the farthest candidate down lets the nearest one win;
    // the farthest candidate is cur itself.
    always_comb begin
        logic [CNT_W-1:0] rem_chk;
        int               idx;
        nxt_found = 1'b0;
        nxt_flow  = cur;
        rem_chk   = '0;
        idx       = 0;
        for (int k = FLUX; k >= 1; k--) begin
            idx     = (int'(cur) + k) % FLUX;
            rem_chk = (idx == int'(cur)) ? rem_cur_dec : remaining[idx];
            if (rem_chk != '0) begin
                nxt_found = 1'b1;
                nxt_flow  = TAG_W'(idx);
            end
        end
    end

    // Lowest active flow at go time; a same-cycle config write is visible here.
    always_comb begin
        logic [CNT_W-1:0] rem_eff;
        start_found = 1'b0;
        start_flow  = '0;
        rem_eff     = '0;
        for (int f = FLUX - 1; f >= 0; f--) begin
            if (cfg_we && cfg_flow_ok && (int'(cfg_flow) == f)) begin
                rem_eff = cfg_total;
            end else begin
                rem_eff = remaining[f];
            end
            if (rem_eff != '0) begin
                start_found = 1'b1;
                start_flow  = TAG_W'(f);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (cfg_go && start_found) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (xfer && blk_end && !nxt_found) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < FLUX; f++) begin
                remaining[f] <= '0;
                blk_len[f]   <= LEN_W'(1);
            end
            cur       <= '0;
            blk_cnt   <= '0;
            done_r    <= 1'b0;
            cfg_err_r <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            cfg_err_r <= 1'b0;
            if (state == S_IDLE) begin
                if (cfg_we && cfg_flow_ok) begin
                    remaining[cfg_flow] <= cfg_total;
                    blk_len[cfg_flow]   <= (cfg_blk_len == '0) ? LEN_W'(1) : cfg_blk_len;
                end
                if (cfg_go) begin
                    if (start_found) begin
                        cur     <= start_flow;
                        blk_cnt <= '0;
                    end else begin
                        cfg_err_r <= 1'b1;
                    end
                end
            end else begin
                if (cfg_we || cfg_go) begin
                    cfg_err_r <= 1'b1;
                end
                if (xfer) begin
                    remaining[cur] <= rem_cur_dec;
                    if (blk_end) begin
                        blk_cnt <= '0;
                        if (nxt_found) begin
                            cur <= nxt_flow;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end else begin
                        blk_cnt <= blk_cnt + LEN_W'(1);
                    end
                end
            end
        end
    end

    // Outputs are forced quiet while reset is held, independent of stored state.
    always_comb begin
        src_read  = '0;
        out_write = 1'b0;
        out_din   = '0;
        if (!rst && xfer) begin
            src_read[cur] = 1'b1;
            out_write     = 1'b1;
            out_din       = {cur, head};
        end
        busy    = !rst && (state == S_RUN);
        done    = !rst && done_r;
        cfg_err = !rst && cfg_err_r;
    end

endmodule
